// File: rtl/trap_pkg.sv
// Shared constants and FSM state type for the machine-mode trap controller.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam int CAUSE_EBREAK = 3;
  localparam int CAUSE_ECALL  = 11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_MEPC    = 3'd1,
    ST_WR_MSTATUS = 3'd2,
    ST_WR_MCAUSE  = 3'd3,
    ST_TRAP_JUMP  = 3'd4,
    ST_MRET_WR    = 3'd5,
    ST_MRET_JUMP  = 3'd6
  } trap_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the masked interrupt lines.
module irq_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan downward so the last hit, i.e. the lowest set line, is what remains.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates ECALL/EBREAK/irq/MRET in ID,
// sequences the mepc/mstatus/mcause writes and issues a one-cycle redirect.
//
//   state         | meaning
//   --------------+----------------------------------------------
//   ST_IDLE       | waiting; requests evaluated combinationally
//   ST_WR_MEPC    | write captured epc to mepc
//   ST_WR_MSTATUS | trap-entry mstatus update (MPIE<=MIE, MIE<=0, MPP<=M)
//   ST_WR_MCAUSE  | write captured cause to mcause
//   ST_TRAP_JUMP  | redirect to handler target
//   ST_MRET_WR    | return mstatus update (MIE<=MPIE, MPIE<=1)
//   ST_MRET_JUMP  | redirect to mepc
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int NUM_IRQ        = 8,
  parameter int XLEN           = 32,
  parameter int IRQ_CAUSE_BASE = 16,
  parameter bit VECTORED_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic [31:0]        inst,
  input  logic [XLEN-1:0]    inst_pc,
  input  logic               jump_flag,
  input  logic [XLEN-1:0]    jump_addr,
  input  logic [XLEN-1:0]    csr_mtvec,
  input  logic [XLEN-1:0]    csr_mepc,
  input  logic [XLEN-1:0]    csr_mstatus,
  output logic               stall_o,
  output logic               csr_we,
  output logic [11:0]        csr_waddr,
  output logic [XLEN-1:0]    csr_wdata,
  output logic               trap_assert,
  output logic [XLEN-1:0]    trap_addr,
  output logic               busy
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] target_q, target_d;

  logic [NUM_IRQ-1:0] irq_req;
  logic               irq_valid;
  logic [IDX_W-1:0]   irq_idx;

  assign irq_req = irq_pending & irq_mask;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_irq_prio_enc (
    .req   (irq_req),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  logic            is_ecall, is_ebreak, sync_req, async_req, mret_req;
  logic            idle, any_req;
  logic [XLEN-1:0] irq_code, mtvec_base, irq_target;
  logic            vec_mode;

  assign is_ecall  = (inst == INST_ECALL);
  assign is_ebreak = (inst == INST_EBREAK);
  assign sync_req  = is_ecall | is_ebreak;
  assign async_req = csr_mstatus[MSTATUS_MIE] & irq_valid;
  assign mret_req  = (inst == INST_MRET);
  assign idle      = (state_q == ST_IDLE);
  assign any_req   = sync_req | async_req | mret_req;

  assign irq_code   = XLEN'(IRQ_CAUSE_BASE) + XLEN'(irq_idx);
  assign mtvec_base = {csr_mtvec[XLEN-1:2], 2'b00};
  assign vec_mode   = VECTORED_EN && (csr_mtvec[1:0] == 2'b01);
  // Vectored offset wraps naturally at XLEN bits.
  assign irq_target = vec_mode ? (mtvec_base + (irq_code << 2)) : mtvec_base;

  assign busy    = ~idle;
  assign stall_o = busy | (idle & any_req);

  function automatic logic [XLEN-1:0] mstatus_enter(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_return(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    target_d = target_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sync_req) begin
          epc_d    = inst_pc;
          cause_d  = is_ecall ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_EBREAK);
          target_d = mtvec_base;
          state_d  = ST_WR_MEPC;
        end else if (async_req) begin
          epc_d             = jump_flag ? jump_addr : inst_pc;
          cause_d           = irq_code;
          cause_d[XLEN-1]   = 1'b1;
          target_d          = irq_target;
          state_d           = ST_WR_MEPC;
        end else if (mret_req) begin
          state_d = ST_MRET_WR;
        end
      end
      ST_WR_MEPC:    state_d = ST_WR_MSTATUS;
      ST_WR_MSTATUS: state_d = ST_WR_MCAUSE;
      ST_WR_MCAUSE:  state_d = ST_TRAP_JUMP;
      ST_TRAP_JUMP:  state_d = ST_IDLE;
      ST_MRET_WR:    state_d = ST_MRET_JUMP;
      ST_MRET_JUMP:  state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

  // Moore decode; mstatus/mepc are read live in the state that uses them.
  always_comb begin
    csr_we      = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    trap_assert = 1'b0;
    trap_addr   = '0;
    unique case (state_q)
      ST_WR_MEPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = epc_q;
      end
      ST_WR_MSTATUS: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mstatus_enter(csr_mstatus);
      end
      ST_WR_MCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_q;
      end
      ST_TRAP_JUMP: begin
        trap_assert = 1'b1;
        trap_addr   = target_q;
      end
      ST_MRET_WR: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mstatus_return(csr_mstatus);
      end
      ST_MRET_JUMP: begin
        trap_assert = 1'b1;
        trap_addr   = csr_mepc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: entry, vectored irq, masking, priority, MRET, reset abort.
module tb_trap_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_pending, irq_mask;
  logic [31:0] inst, inst_pc, jump_addr, csr_mtvec, csr_mepc, csr_mstatus;
  logic        jump_flag;
  logic        stall_o, csr_we, trap_assert, busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, trap_addr;

  int n_cmp = 0;
  int n_err = 0;
  logic [79:0] exp_v;

  trap_ctrl #(.NUM_IRQ(8), .XLEN(32), .IRQ_CAUSE_BASE(16), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .irq_pending(irq_pending), .irq_mask(irq_mask),
    .inst(inst), .inst_pc(inst_pc), .jump_flag(jump_flag), .jump_addr(jump_addr),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
    .stall_o(stall_o), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .trap_assert(trap_assert), .trap_addr(trap_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] obs();
    return {stall_o, busy, csr_we, csr_waddr, csr_wdata, trap_assert, trap_addr};
  endfunction

  function automatic logic [79:0] pack(input logic s, input logic b, input logic we,
                                       input logic [11:0] a, input logic [31:0] d,
                                       input logic ta, input logic [31:0] t);
    return {s, b, we, a, d, ta, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq_pending = '0; irq_mask = '0; inst = NOP; inst_pc = '0; jump_flag = 1'b0;
    jump_addr = '0; csr_mtvec = '0; csr_mepc = '0; csr_mstatus = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step(); step();
    exp_v = pack('0, '0, '0, '0, '0, '0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL reset_hold: got %h want %h", obs(), exp_v); end
    rst = 1'b0;
    step();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL reset_release: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_ecall();
    inst = ECALL; inst_pc = 32'h100; csr_mtvec = 32'h200; csr_mstatus = 32'h8;
    #1;
    exp_v = pack(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ecall_accept: got %h want %h", obs(), exp_v); end
    step(); inst = NOP; #1;
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h341, 32'h100, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ecall_mepc: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h300, 32'h1880, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ecall_mstatus: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h342, 32'd11, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ecall_mcause: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 32'h200);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ecall_jump: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack('0, '0, '0, '0, '0, '0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ecall_done: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_irq_vectored();
    idle_inputs();
    irq_pending = 8'b0010_0100; irq_mask = 8'hFF; csr_mstatus = 32'h8; csr_mtvec = 32'h301;
    jump_flag = 1'b1; jump_addr = 32'h440; inst_pc = 32'h120;
    #1;
    exp_v = pack(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL irq_accept: got %h want %h", obs(), exp_v); end
    // Source drops right after acceptance; captured cause must survive.
    step(); irq_pending = '0; jump_flag = 1'b0; #1;
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h341, 32'h440, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL irq_mepc: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h300, 32'h1880, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL irq_mstatus: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h342, 32'h8000_0012, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL irq_mcause: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 32'h348);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL irq_jump: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack('0, '0, '0, '0, '0, '0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL irq_done: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_irq_blocked();
    idle_inputs();
    irq_pending = 8'b0010_0100; irq_mask = 8'hFF; csr_mstatus = 32'h0; csr_mtvec = 32'h301;
    #1;
    exp_v = pack('0, '0, '0, '0, '0, '0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL irq_mie0: got %h want %h", obs(), exp_v); end
    step();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL irq_mie0_next: got %h want %h", obs(), exp_v); end
    csr_mstatus = 32'h8; irq_mask = 8'h00; #1;
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL irq_mask0: got %h want %h", obs(), exp_v); end
    step();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL irq_mask0_next: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_ecall_vs_irq();
    idle_inputs();
    inst = ECALL; inst_pc = 32'h180; irq_pending = 8'h01; irq_mask = 8'hFF;
    csr_mstatus = 32'h8; csr_mtvec = 32'h301;
    step(); inst = NOP; #1;
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h341, 32'h180, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL prio_mepc: got %h want %h", obs(), exp_v); end
    step(); step();
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h342, 32'd11, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL prio_mcause: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 32'h300);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL prio_jump: got %h want %h", obs(), exp_v); end
    csr_mstatus = 32'h1880;
    step();
    exp_v = pack('0, '0, '0, '0, '0, '0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL prio_irq_held_mie0: got %h want %h", obs(), exp_v); end
    csr_mstatus = 32'h1888; #1;
    exp_v = pack(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL prio_irq_retake: got %h want %h", obs(), exp_v); end
    step(); irq_pending = '0; step();
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h300, 32'h1880, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL prio_irq_mstatus: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h342, 32'h8000_0010, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL prio_irq_mcause: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 32'h340);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL prio_irq_jump: got %h want %h", obs(), exp_v); end
    step();
  endtask

  task automatic test_mret();
    idle_inputs();
    inst = MRET; csr_mstatus = 32'h1880; csr_mepc = 32'h104;
    #1;
    exp_v = pack(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL mret_accept: got %h want %h", obs(), exp_v); end
    step(); inst = NOP; #1;
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h300, 32'h1888, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL mret_mstatus: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 32'h104);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL mret_jump: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack('0, '0, '0, '0, '0, '0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL mret_done: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_ebreak_mode10();
    idle_inputs();
    inst = EBREAK; inst_pc = 32'h1a0; csr_mstatus = 32'h8; csr_mtvec = 32'h301;
    step(); inst = NOP; step(); step();
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h342, 32'd3, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ebreak_mcause: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 32'h300);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ebreak_jump: got %h want %h", obs(), exp_v); end
    step();
    // mtvec mode 2'b10 behaves as direct even for an irq.
    irq_pending = 8'h80; irq_mask = 8'h80; csr_mtvec = 32'h302;
    step(); irq_pending = '0; step(); step();
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h342, 32'h8000_0017, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL mode10_mcause: got %h want %h", obs(), exp_v); end
    step();
    exp_v = pack(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 32'h300);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL mode10_jump: got %h want %h", obs(), exp_v); end
    step();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    inst = ECALL; inst_pc = 32'h100; csr_mtvec = 32'h200; csr_mstatus = 32'h8;
    step(); inst = NOP; step();
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h300, 32'h1880, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rstmid_pre: got %h want %h", obs(), exp_v); end
    rst = 1'b1; #1;
    exp_v = pack('0, '0, '0, '0, '0, '0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rstmid_abort: got %h want %h", obs(), exp_v); end
    step(); rst = 1'b0; step();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rstmid_idle: got %h want %h", obs(), exp_v); end
    inst = ECALL; inst_pc = 32'h210;
    step(); inst = NOP; #1;
    exp_v = pack(1'b1, 1'b1, 1'b1, 12'h341, 32'h210, 1'b0, '0);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rstmid_rerun_mepc: got %h want %h", obs(), exp_v); end
    step(); step(); step();
    exp_v = pack(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 32'h200);
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rstmid_rerun_jump: got %h want %h", obs(), exp_v); end
    step();
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_irq_vectored();
    test_irq_blocked();
    test_ecall_vs_irq();
    test_mret();
    test_ebreak_mode10();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Parametrised machine-mode trap controller in the ID stage. It arbitrates N masked interrupt lines and the synchronous ECALL/EBREAK/MRET instructions. For each accepted trap it sequences the CSR writes (mepc, mstatus, mcause), stalls the pipeline, and then issues a one-cycle redirect to the handler or return address. Supports direct and vectored mtvec modes; generalises the fixed 8-line, direct-only controller.

Parameters:
NUM_IRQ, 8, number of interrupt lines (1..32)
XLEN, 32, data/address width
IRQ_CAUSE_BASE, 16, mcause code of irq line 0; line i gets IRQ_CAUSE_BASE+i
VECTORED_EN, 1, 1 = honour mtvec[1:0]==01 vectored mode; 0 = always direct

Ports:
clk  in  1  clock
rst  in  1  reset
irq_pending  in  NUM_IRQ  level interrupt requests
irq_mask  in  NUM_IRQ  per-line enable (mie equivalent)
inst  in  32  instruction in ID
inst_pc  in  XLEN  PC of inst
jump_flag  in  1  EX redirect pending
jump_addr  in  XLEN  EX redirect target
csr_mtvec  in  XLEN  current mtvec
csr_mepc  in  XLEN  current mepc
csr_mstatus  in  XLEN  current mstatus
stall_o  out  1  hold IF/ID
csr_we  out  1  CSR write strobe
csr_waddr  out  12  CSR write address
csr_wdata  out  XLEN  CSR write data
trap_assert  out  1  one-cycle redirect strobe
trap_addr  out  XLEN  redirect target
busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, active-high) is already decided; clock clk. Reset forces state IDLE and clears captured epc/cause/target. All outputs are 0 while rst is high and in IDLE with no request.
- Request detection is combinational and evaluated only in IDLE. Priority: ECALL (32'h00000073) / EBREAK (32'h00100073) > async irq > MRET (32'h30200073).
- Async irq is accepted iff csr_mstatus[3] (MIE) and |(irq_pending & irq_mask). The lowest index wins.
- stall_o = busy | (IDLE & any accepted request). It is combinational so the triggering instruction is held the same cycle.
- Capture on acceptance:
  - Sync: epc = inst_pc; cause = 11 (ECALL) or 3 (EBREAK).
  - Async: epc = jump_flag ? jump_addr : inst_pc; cause = {1'b1, IRQ_CAUSE_BASE+idx} zero-extended to XLEN.
- FSM states: IDLE, WR_MEPC, WR_MSTATUS, WR_MCAUSE, TRAP_JUMP, MRET_WR, MRET_JUMP.
- Trap entry path: IDLE -> WR_MEPC -> WR_MSTATUS -> WR_MCAUSE -> TRAP_JUMP -> IDLE. Latency is 4 cycles from acceptance to trap_assert.
- MRET path: IDLE -> MRET_WR -> MRET_JUMP -> IDLE.
- Outputs are Moore-decoded from state:
  - WR_MEPC: we=1, addr 12'h341, data=epc.
  - WR_MSTATUS: we=1, addr 12'h300, data = csr_mstatus with bit7 <= bit3, bit3 <= 0, bits[12:11] <= 2'b11. csr_mstatus is sampled in this cycle.
  - WR_MCAUSE: we=1, addr 12'h342, data=cause.
  - TRAP_JUMP: trap_assert=1, trap_addr = target, we=0.
  - MRET_WR: we=1, addr 12'h300, data = csr_mstatus with bit3 <= bit7, bit7 <= 1.
  - MRET_JUMP: trap_assert=1, trap_addr=csr_mepc.
  - In every other state, csr_we/csr_waddr/csr_wdata/trap_assert/trap_addr are 0.
- Target computation:
  - base = {csr_mtvec[XLEN-1:2], 2'b00}.
  - If VECTORED_EN and mtvec[1:0]==2'b01 and cause is async: target = base + (cause_code << 2), modulo 2^XLEN wrap.
  - Otherwise target = base.
  - mtvec[1:0] in {10,11} is treated as direct.
- Requests arriving while busy are ignored, not queued; level sources re-present after return.
- If irq_pending drops mid-sequence, the sequence completes with the captured cause.
- Async reset mid-sequence aborts immediately to IDLE; a partially written CSR set is acceptable.
- busy = (state != IDLE).

Decomposition:
- trap_pkg:
  - CSR address constants MSTATUS/MEPC/MCAUSE.
  - ECALL/EBREAK/MRET encodings.
  - Cause codes 3/11.
  - mstatus bit indices MIE=3, MPIE=7, MPP=12:11.
  - FSM state enum (3-bit).
- One sub-module, irq_prio_enc: parametrised NUM_IRQ lowest-index priority encoder producing valid and a $clog2(NUM_IRQ)-bit index.

Test Plan:
- ECALL at inst_pc=0x100, mtvec=0x200, mstatus=0x8 -> csr writes in order: 0x341<=0x100, 0x300<=0x1880, 0x342<=11; then trap_assert with trap_addr=0x200 on cycle 4; stall_o high cycles 0-4.
- irq_pending=8'b0010_0100, irq_mask=0xFF, MIE=1, mtvec=0x301 (vectored), jump_flag=1, jump_addr=0x440 -> mepc<=0x440, mcause<=0x80000012, trap_addr=0x300+0x48=0x348.
- Same irq with MIE=0 or irq_mask=0 -> no stall, no writes, busy=0.
- ECALL and irq asserted in the same cycle -> ECALL path taken, mcause=11. The irq is taken after return only if still pending and MIE=1.
- MRET with mstatus=0x1880, mepc=0x104 -> 0x300<=0x1888, then trap_assert with trap_addr=0x104; 2-cycle sequence.
- rst pulsed during WR_MSTATUS -> state IDLE and all outputs 0 immediately; a new ECALL after release runs the full sequence from WR_MEPC.
